// File: rtl/id_decode_stage.sv
// RV32IC instruction-decode stage: RVC expansion, decode, operand read
// and the ID/EX pipeline register with load-use interlock and flush.
module id_decode_stage #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter bit C_EXT      = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_valid,
    output logic                  if_ready,
    input  logic [31:0]           if_instr,
    input  logic [XLEN-1:0]       if_pc,
    input  logic                  flush,
    input  logic                  ex_ready,
    output logic [REG_ADDR_W-1:0] rf_rs1_addr,
    output logic [REG_ADDR_W-1:0] rf_rs2_addr,
    input  logic [XLEN-1:0]       rf_rs1_data,
    input  logic [XLEN-1:0]       rf_rs2_data,
    output logic                  ex_valid,
    output logic [XLEN-1:0]       ex_pc,
    output logic [XLEN-1:0]       ex_rs1_val,
    output logic [XLEN-1:0]       ex_rs2_val,
    output logic [XLEN-1:0]       ex_imm,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic [3:0]            ex_alu_op,
    output logic                  ex_is_load,
    output logic                  ex_is_store,
    output logic                  ex_is_branch,
    output logic                  ex_is_jump,
    output logic                  ex_is_compressed,
    output logic                  ex_illegal
);

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
    } alu_e;

    typedef struct packed {
        logic [XLEN-1:0]       pc;
        logic [XLEN-1:0]       rs1;
        logic [XLEN-1:0]       rs2;
        logic [XLEN-1:0]       imm;
        logic [REG_ADDR_W-1:0] rd;
        logic [3:0]            alu;
        logic                  ld;
        logic                  st;
        logic                  br;
        logic                  jp;
        logic                  c;
        logic                  ill;
    } id_ex_t;

    localparam logic [6:0] OP_LUI   = 7'h37;
    localparam logic [6:0] OP_AUIPC = 7'h17;
    localparam logic [6:0] OP_JAL   = 7'h6f;
    localparam logic [6:0] OP_JALR  = 7'h67;
    localparam logic [6:0] OP_BR    = 7'h63;
    localparam logic [6:0] OP_LD    = 7'h03;
    localparam logic [6:0] OP_ST    = 7'h23;
    localparam logic [6:0] OP_IMM   = 7'h13;
    localparam logic [6:0] OP_REG   = 7'h33;
    localparam logic [6:0] OP_FENCE = 7'h0f;

    // Register-field bits that do not exist in the configured file.
    localparam logic [4:0] HI = ~5'((1 << REG_ADDR_W) - 1);

    function automatic logic [31:0] f_i(input logic [11:0] imm,
        input logic [4:0] rs1, input logic [2:0] f3,
        input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] f_s(input logic [11:0] imm,
        input logic [4:0] rs2, input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OP_ST};
    endfunction

    function automatic logic [31:0] f_b(input logic [12:0] imm,
        input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], 5'd0, rs1, f3,
                imm[4:1], imm[11], OP_BR};
    endfunction

    function automatic logic [31:0] f_j(input logic [20:0] imm,
        input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
    endfunction

    function automatic logic [31:0] f_r(input logic [6:0] f7,
        input logic [4:0] rs2, input logic [4:0] rs1,
        input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, OP_REG};
    endfunction

    // Returns {reserved, expanded 32-bit word}.
    function automatic logic [32:0] f_expand(input logic [15:0] c);
        logic [4:0]  rd;
        logic [4:0]  rs2;
        logic [4:0]  rdp;
        logic [4:0]  rs2p;
        logic [11:0] imm6;
        logic [11:0] imm;
        logic [20:0] jimm;
        logic [12:0] bimm;
        logic [2:0]  af3;
        logic        bad;
        logic [31:0] w;
        rd   = c[11:7];
        rs2  = c[6:2];
        rdp  = {2'b01, c[9:7]};
        rs2p = {2'b01, c[4:2]};
        imm6 = {{6{c[12]}}, c[12], c[6:2]};
        jimm = {{9{c[12]}}, c[12], c[8], c[10:9], c[6], c[7],
                c[2], c[11], c[5:3], 1'b0};
        bimm = {{4{c[12]}}, c[12], c[6:5], c[2], c[11:10],
                c[4:3], 1'b0};
        af3  = {c[6] | c[5], c[6], c[6] & c[5]};
        imm  = 12'h0;
        bad  = 1'b0;
        w    = 32'h0;
        case ({c[1:0], c[15:13]})
            5'b00_000: begin
                imm = {2'b00, c[10:7], c[12:11], c[5], c[6], 2'b00};
                w   = f_i(imm, 5'd2, 3'b000, rs2p, OP_IMM);
                bad = (c[12:5] == 8'h0);
            end
            5'b00_010: begin
                imm = {5'b0, c[5], c[12:10], c[6], 2'b00};
                w   = f_i(imm, rdp, 3'b010, rs2p, OP_LD);
            end
            5'b00_110: begin
                imm = {5'b0, c[5], c[12:10], c[6], 2'b00};
                w   = f_s(imm, rs2p, rdp);
            end
            5'b01_000: w = f_i(imm6, rd, 3'b000, rd, OP_IMM);
            5'b01_001: w = f_j(jimm, 5'd1);
            5'b01_010: w = f_i(imm6, 5'd0, 3'b000, rd, OP_IMM);
            5'b01_011: begin
                bad = ({c[12], c[6:2]} == 6'h0);
                if (rd == 5'd2) begin
                    imm = {{2{c[12]}}, c[12], c[4:3], c[5], c[2],
                           c[6], 4'b0};
                    w   = f_i(imm, 5'd2, 3'b000, 5'd2, OP_IMM);
                end else begin
                    w = {{14{c[12]}}, c[12], c[6:2], rd, OP_LUI};
                end
            end
            5'b01_100: begin
                case (c[11:10])
                    2'b00: begin
                        w   = f_i({7'h00, c[6:2]}, rdp, 3'b101, rdp, OP_IMM);
                        bad = c[12];
                    end
                    2'b01: begin
                        w   = f_i({7'h20, c[6:2]}, rdp, 3'b101, rdp, OP_IMM);
                        bad = c[12];
                    end
                    2'b10: w = f_i(imm6, rdp, 3'b111, rdp, OP_IMM);
                    default: begin
                        w   = f_r((c[6:5] == 2'b00) ? 7'h20 : 7'h00,
                                  rs2p, rdp, af3, rdp);
                        bad = c[12];
                    end
                endcase
            end
            5'b01_101: w = f_j(jimm, 5'd0);
            5'b01_110: w = f_b(bimm, rdp, 3'b000);
            5'b01_111: w = f_b(bimm, rdp, 3'b001);
            5'b10_000: begin
                w   = f_i({7'h00, c[6:2]}, rd, 3'b001, rd, OP_IMM);
                bad = c[12];
            end
            5'b10_010: begin
                imm = {4'b0, c[3:2], c[12], c[6:4], 2'b00};
                w   = f_i(imm, 5'd2, 3'b010, rd, OP_LD);
                bad = (rd == 5'd0);
            end
            5'b10_100: begin
                if (!c[12]) begin
                    if (rs2 == 5'd0) begin
                        w   = f_i(12'h0, rd, 3'b000, 5'd0, OP_JALR);
                        bad = (rd == 5'd0);
                    end else begin
                        w = f_r(7'h00, rs2, 5'd0, 3'b000, rd);
                    end
                end else if (rs2 != 5'd0) begin
                    w = f_r(7'h00, rs2, rd, 3'b000, rd);
                end else if (rd == 5'd0) begin
                    w = 32'h0010_0073;
                end else begin
                    w = f_i(12'h0, rd, 3'b000, 5'd1, OP_JALR);
                end
            end
            5'b10_110: begin
                imm = {4'b0, c[8:7], c[12:9], 2'b00};
                w   = f_s(imm, rs2, 5'd2);
            end
            default: bad = 1'b1;
        endcase
        return {bad, w};
    endfunction

    function automatic logic [3:0] f_alu(input logic [2:0] f3,
        input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    id_ex_t      r_ex;
    logic        r_valid;
    id_ex_t      w_dec;
    logic [32:0] w_exp;
    logic        w_is_c;
    logic [31:0] w_word;
    logic [6:0]  w_op;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [4:0]  w_rdf;
    logic [4:0]  w_rs1f;
    logic [4:0]  w_rs2f;
    logic [31:0] w_imm32;
    logic [3:0]  w_alu;
    logic        w_ill;
    logic        w_use1;
    logic        w_use2;
    logic        w_wr;
    logic        w_ld;
    logic        w_st;
    logic        w_br;
    logic        w_jp;
    logic        w_haz;

    assign w_exp  = f_expand(if_instr[15:0]);
    assign w_is_c = (if_instr[1:0] != 2'b11);
    assign w_word = (w_is_c && C_EXT) ? w_exp[31:0] : if_instr;
    assign w_op   = w_word[6:0];
    assign w_rdf  = w_word[11:7];
    assign w_f3   = w_word[14:12];
    assign w_rs1f = w_word[19:15];
    assign w_rs2f = w_word[24:20];
    assign w_f7   = w_word[31:25];

    always_comb begin
        w_alu   = ALU_ADD;
        w_imm32 = 32'h0;
        w_ill   = 1'b0;
        w_use1  = 1'b0;
        w_use2  = 1'b0;
        w_wr    = 1'b0;
        w_ld    = 1'b0;
        w_st    = 1'b0;
        w_br    = 1'b0;
        w_jp    = 1'b0;
        case (w_op)
            OP_LUI: begin
                w_wr    = 1'b1;
                w_alu   = ALU_PASS_B;
                w_imm32 = {w_word[31:12], 12'h0};
            end
            OP_AUIPC: begin
                w_wr    = 1'b1;
                w_imm32 = {w_word[31:12], 12'h0};
            end
            OP_JAL: begin
                w_wr    = 1'b1;
                w_jp    = 1'b1;
                w_imm32 = {{12{w_word[31]}}, w_word[19:12], w_word[20],
                           w_word[30:21], 1'b0};
            end
            OP_JALR: begin
                w_wr    = 1'b1;
                w_jp    = 1'b1;
                w_use1  = 1'b1;
                w_imm32 = {{20{w_word[31]}}, w_word[31:20]};
                w_ill   = (w_f3 != 3'b000);
            end
            OP_BR: begin
                w_br    = 1'b1;
                w_use1  = 1'b1;
                w_use2  = 1'b1;
                w_imm32 = {{20{w_word[31]}}, w_word[7], w_word[30:25],
                           w_word[11:8], 1'b0};
                w_alu   = !w_f3[2] ? ALU_SUB : (w_f3[1] ? ALU_SLTU : ALU_SLT);
                w_ill   = (w_f3[2:1] == 2'b01);
            end
            OP_LD: begin
                w_wr    = 1'b1;
                w_ld    = 1'b1;
                w_use1  = 1'b1;
                w_imm32 = {{20{w_word[31]}}, w_word[31:20]};
                w_ill   = (w_f3[1:0] == 2'b11) || (w_f3[2] && w_f3[1]);
            end
            OP_ST: begin
                w_st    = 1'b1;
                w_use1  = 1'b1;
                w_use2  = 1'b1;
                w_imm32 = {{20{w_word[31]}}, w_word[31:25], w_word[11:7]};
                w_ill   = w_f3[2] || (w_f3[1:0] == 2'b11);
            end
            OP_IMM: begin
                w_wr    = 1'b1;
                w_use1  = 1'b1;
                w_imm32 = {{20{w_word[31]}}, w_word[31:20]};
                w_alu   = f_alu(w_f3, (w_f3 == 3'b101) && w_f7[5]);
                if (w_f3 == 3'b001)
                    w_ill = (w_f7 != 7'h00);
                else if (w_f3 == 3'b101)
                    w_ill = ((w_f7 & 7'h5f) != 7'h00);
            end
            OP_REG: begin
                w_wr   = 1'b1;
                w_use1 = 1'b1;
                w_use2 = 1'b1;
                w_alu  = f_alu(w_f3, w_f7[5]);
                w_ill  = ((w_f7 & 7'h5f) != 7'h00) ||
                         (w_f7[5] && w_f3 != 3'b000 && w_f3 != 3'b101);
            end
            OP_FENCE: w_ill = (w_f3 != 3'b000);
            default:  w_ill = 1'b1;
        endcase
        if ((w_wr && |(w_rdf & HI)) || (w_use1 && |(w_rs1f & HI)) ||
            (w_use2 && |(w_rs2f & HI)))
            w_ill = 1'b1;
        if (w_is_c && (!C_EXT || w_exp[32]))
            w_ill = 1'b1;
        // Illegal words travel down as pure traps: no reads, no side effects.
        if (w_ill) begin
            w_wr   = 1'b0;
            w_ld   = 1'b0;
            w_st   = 1'b0;
            w_br   = 1'b0;
            w_jp   = 1'b0;
            w_use1 = 1'b0;
            w_use2 = 1'b0;
        end
    end

    assign rf_rs1_addr = w_use1 ? w_rs1f[REG_ADDR_W-1:0] : '0;
    assign rf_rs2_addr = w_use2 ? w_rs2f[REG_ADDR_W-1:0] : '0;

    always_comb begin
        w_dec     = '0;
        w_dec.pc  = if_pc;
        w_dec.rs1 = rf_rs1_data;
        w_dec.rs2 = rf_rs2_data;
        w_dec.imm = XLEN'($signed(w_imm32));
        w_dec.rd  = w_wr ? w_rdf[REG_ADDR_W-1:0] : '0;
        w_dec.alu = w_alu;
        w_dec.ld  = w_ld;
        w_dec.st  = w_st;
        w_dec.br  = w_br;
        w_dec.jp  = w_jp;
        w_dec.c   = w_is_c && !w_ill;
        w_dec.ill = w_ill;
    end

    assign w_haz = r_valid && r_ex.ld && (r_ex.rd != '0) &&
                   ((w_use1 && rf_rs1_addr == r_ex.rd) ||
                    (w_use2 && rf_rs2_addr == r_ex.rd));

    assign if_ready = flush || (!w_haz && (!r_valid || ex_ready));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= 1'b0;
            r_ex    <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (!(r_valid && !ex_ready)) begin
            if (w_haz) begin
                r_valid <= 1'b0;
            end else if (if_valid) begin
                r_valid <= 1'b1;
                r_ex    <= w_dec;
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    assign ex_valid         = r_valid;
    assign ex_pc            = r_ex.pc;
    assign ex_rs1_val       = r_ex.rs1;
    assign ex_rs2_val       = r_ex.rs2;
    assign ex_imm           = r_ex.imm;
    assign ex_rd            = r_ex.rd;
    assign ex_alu_op        = r_ex.alu;
    assign ex_is_load       = r_ex.ld;
    assign ex_is_store      = r_ex.st;
    assign ex_is_branch     = r_ex.br;
    assign ex_is_jump       = r_ex.jp;
    assign ex_is_compressed = r_ex.c;
    assign ex_illegal       = r_ex.ill;

endmodule

// File: tb/tb_id_decode_stage.sv
// Directed bench for id_decode_stage: default build, C_EXT=0 build and
// RV32E build all driven by one instruction stream.
module tb_id_decode_stage;

    logic        clk;
    logic        reset;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        flush;
    logic        ex_ready;

    int n_chk = 0;
    int n_err = 0;

    // default instance
    logic        a_rdy, a_v, a_ld, a_st, a_br, a_jp, a_c, a_ill;
    logic [4:0]  a_a1, a_a2, a_rd;
    logic [31:0] a_d1, a_d2, a_pc, a_r1, a_r2, a_imm;
    logic [3:0]  a_alu;
    // C_EXT = 0 instance
    logic        b_rdy, b_v, b_ld, b_st, b_br, b_jp, b_c, b_ill;
    logic [4:0]  b_a1, b_a2, b_rd;
    logic [31:0] b_d1, b_d2, b_pc, b_r1, b_r2, b_imm;
    logic [3:0]  b_alu;
    // REG_ADDR_W = 4 instance
    logic        e_rdy, e_v, e_ld, e_st, e_br, e_jp, e_c, e_ill;
    logic [3:0]  e_a1, e_a2, e_rd;
    logic [31:0] e_d1, e_d2, e_pc, e_r1, e_r2, e_imm;
    logic [3:0]  e_alu;

    assign a_d1 = 32'h1000 + 32'(a_a1);
    assign a_d2 = 32'h1000 + 32'(a_a2);
    assign b_d1 = 32'h1000 + 32'(b_a1);
    assign b_d2 = 32'h1000 + 32'(b_a2);
    assign e_d1 = 32'h1000 + 32'(e_a1);
    assign e_d2 = 32'h1000 + 32'(e_a2);

    id_decode_stage u_dut (
        .clk(clk), .reset(reset), .if_valid(if_valid), .if_ready(a_rdy),
        .if_instr(if_instr), .if_pc(if_pc), .flush(flush),
        .ex_ready(ex_ready), .rf_rs1_addr(a_a1), .rf_rs2_addr(a_a2),
        .rf_rs1_data(a_d1), .rf_rs2_data(a_d2), .ex_valid(a_v),
        .ex_pc(a_pc), .ex_rs1_val(a_r1), .ex_rs2_val(a_r2),
        .ex_imm(a_imm), .ex_rd(a_rd), .ex_alu_op(a_alu),
        .ex_is_load(a_ld), .ex_is_store(a_st), .ex_is_branch(a_br),
        .ex_is_jump(a_jp), .ex_is_compressed(a_c), .ex_illegal(a_ill)
    );

    id_decode_stage #(.C_EXT(1'b0)) u_noc (
        .clk(clk), .reset(reset), .if_valid(if_valid), .if_ready(b_rdy),
        .if_instr(if_instr), .if_pc(if_pc), .flush(flush),
        .ex_ready(ex_ready), .rf_rs1_addr(b_a1), .rf_rs2_addr(b_a2),
        .rf_rs1_data(b_d1), .rf_rs2_data(b_d2), .ex_valid(b_v),
        .ex_pc(b_pc), .ex_rs1_val(b_r1), .ex_rs2_val(b_r2),
        .ex_imm(b_imm), .ex_rd(b_rd), .ex_alu_op(b_alu),
        .ex_is_load(b_ld), .ex_is_store(b_st), .ex_is_branch(b_br),
        .ex_is_jump(b_jp), .ex_is_compressed(b_c), .ex_illegal(b_ill)
    );

    id_decode_stage #(.REG_ADDR_W(4)) u_rve (
        .clk(clk), .reset(reset), .if_valid(if_valid), .if_ready(e_rdy),
        .if_instr(if_instr), .if_pc(if_pc), .flush(flush),
        .ex_ready(ex_ready), .rf_rs1_addr(e_a1), .rf_rs2_addr(e_a2),
        .rf_rs1_data(e_d1), .rf_rs2_data(e_d2), .ex_valid(e_v),
        .ex_pc(e_pc), .ex_rs1_val(e_r1), .ex_rs2_val(e_r2),
        .ex_imm(e_imm), .ex_rd(e_rd), .ex_alu_op(e_alu),
        .ex_is_load(e_ld), .ex_is_store(e_st), .ex_is_branch(e_br),
        .ex_is_jump(e_jp), .ex_is_compressed(e_c), .ex_illegal(e_ill)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] ins, input logic [31:0] pc);
        if_valid = 1'b1;
        if_instr = ins;
        if_pc    = pc;
    endtask

    initial begin
        clk      = 1'b0;
        reset    = 1'b0;
        if_valid = 1'b0;
        if_instr = 32'h0;
        if_pc    = 32'h0;
        flush    = 1'b0;
        ex_ready = 1'b1;
        #1;
        chk("rst_valid", 32'(a_v), 32'd0);
        chk("rst_pc", a_pc, 32'h0);
        chk("rst_ready", 32'(a_rdy), 32'd1);
        step();
        step();
        reset = 1'b1;

        // ADDI x1,x0,5 then ADD x2,x1,x1
        drive(32'h0050_0093, 32'h100);
        #1;
        chk("addi_rs1a", 32'(a_a1), 32'd0);
        step();
        chk("addi_valid", 32'(a_v), 32'd1);
        chk("addi_pc", a_pc, 32'h100);
        chk("addi_imm", a_imm, 32'd5);
        chk("addi_rd", 32'(a_rd), 32'd1);
        chk("addi_alu", 32'(a_alu), 32'd0);
        drive(32'h0010_8133, 32'h104);
        #1;
        chk("add_rs1a", 32'(a_a1), 32'd1);
        chk("add_rs2a", 32'(a_a2), 32'd1);
        chk("add_ready", 32'(a_rdy), 32'd1);
        step();
        chk("add_valid", 32'(a_v), 32'd1);
        chk("add_pc", a_pc, 32'h104);
        chk("add_rd", 32'(a_rd), 32'd2);
        chk("add_rs1v", a_r1, 32'h1001);

        // LW x5,0(x2) then ADD x6,x5,x0 -> one bubble
        drive(32'h0001_2283, 32'h108);
        step();
        chk("lw_load", 32'(a_ld), 32'd1);
        chk("lw_rd", 32'(a_rd), 32'd5);
        drive(32'h0002_8333, 32'h10C);
        #1;
        chk("lu_stall", 32'(a_rdy), 32'd0);
        step();
        chk("lu_bubble", 32'(a_v), 32'd0);
        chk("lu_ready", 32'(a_rdy), 32'd1);
        step();
        chk("lu_valid", 32'(a_v), 32'd1);
        chk("lu_pc", a_pc, 32'h10C);
        chk("lu_rd", 32'(a_rd), 32'd6);
        chk("lu_rs1v", a_r1, 32'h1005);

        // LW x0 then use of x0 -> no stall
        drive(32'h0001_2003, 32'h110);
        step();
        chk("lw0_rd", 32'(a_rd), 32'd0);
        drive(32'h0000_0333, 32'h114);
        #1;
        chk("lw0_ready", 32'(a_rdy), 32'd1);
        step();
        chk("lw0_pc", a_pc, 32'h114);

        // C.ADDI x8,-1
        drive(32'h0000_147D, 32'h118);
        step();
        chk("caddi_c", 32'(a_c), 32'd1);
        chk("caddi_rd", 32'(a_rd), 32'd8);
        chk("caddi_imm", a_imm, 32'hFFFF_FFFF);
        chk("caddi_ill", 32'(a_ill), 32'd0);
        chk("caddi_rs1v", a_r1, 32'h1008);
        chk("noc_ill", 32'(b_ill), 32'd1);
        chk("noc_rd", 32'(b_rd), 32'd0);

        // back-pressure hold, then flush
        ex_ready = 1'b0;
        drive(32'h0070_0193, 32'h11C);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("hold_ready", 32'(a_rdy), 32'd0);
            step();
            chk("hold_valid", 32'(a_v), 32'd1);
            chk("hold_pc", a_pc, 32'h118);
            chk("hold_imm", a_imm, 32'hFFFF_FFFF);
        end
        flush = 1'b1;
        #1;
        chk("flush_ready", 32'(a_rdy), 32'd1);
        step();
        chk("flush_valid", 32'(a_v), 32'd0);
        chk("flush_pc", a_pc, 32'h118);
        flush    = 1'b0;
        ex_ready = 1'b1;
        step();
        chk("post_valid", 32'(a_v), 32'd1);
        chk("post_pc", a_pc, 32'h11C);
        chk("post_imm", a_imm, 32'd7);
        chk("post_rd", 32'(a_rd), 32'd3);

        // ADD x16 / ADD x15 on RV32E
        drive(32'h0020_8833, 32'h120);
        step();
        chk("e16_ill", 32'(e_ill), 32'd1);
        chk("e16_rd", 32'(e_rd), 32'd0);
        chk("i16_ill", 32'(a_ill), 32'd0);
        chk("i16_rd", 32'(a_rd), 32'd16);
        drive(32'h0020_87B3, 32'h124);
        step();
        chk("e15_ill", 32'(e_ill), 32'd0);
        chk("e15_rd", 32'(e_rd), 32'd15);

        // reserved all-zero RVC, then BNE x1,x2,-8
        drive(32'h0000_0000, 32'h128);
        step();
        chk("c0_ill", 32'(a_ill), 32'd1);
        chk("c0_c", 32'(a_c), 32'd0);
        drive(32'hFE20_9CE3, 32'h12A);
        step();
        chk("bne_br", 32'(a_br), 32'd1);
        chk("bne_imm", a_imm, 32'hFFFF_FFF8);
        chk("bne_rd", 32'(a_rd), 32'd0);
        chk("bne_alu", 32'(a_alu), 32'd1);
        chk("bne_rs2v", a_r2, 32'h1002);

        // asynchronous reset with ex_valid=1
        chk("pre_rst_v", 32'(a_v), 32'd1);
        #1;
        reset = 1'b0;
        #1;
        chk("arst_valid", 32'(a_v), 32'd0);
        chk("arst_pc", a_pc, 32'h0);
        chk("arst_imm", a_imm, 32'h0);
        chk("arst_br", 32'(a_br), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
